// File: rtl/fetch_unit_r32i.sv
// fetch_unit_r32i: RV32I instruction fetch stage.
// Owns the program counter, fetches one word at a time over IMemReq/IMemAck
// and hands each instruction, with its address and return address, to the
// decoder over InsValid/InsReady. A redirect discards any wrong-path fetch.
// If a request is still waiting for its ack, the stage holds the old address
// until that ack arrives and only then fetches from the new PC.
// Build option MISALIGN_TRAP_EN: a redirect to a non-word-aligned target
// parks the stage in a terminal FAULT state. Without it, the low two target
// bits are cleared instead.

module fetch_unit_r32i #(
   parameter int unsigned      dataW       = 32,
   parameter logic [dataW-1:0] ResetVector = '0
) (
   input  logic             Clock,
   input  logic             Reset,
   output logic             IMemReq,
   output logic [dataW-1:0] IMemAddr,
   input  logic             IMemAck,
   input  logic [dataW-1:0] IMemData,
   output logic             InsValid,
   input  logic             InsReady,
   output logic [dataW-1:0] RawIns,
   output logic [dataW-1:0] ProgAddr,
   output logic [dataW-1:0] LinkAddr,
   input  logic             Redirect,
   input  logic [dataW-1:0] RedirectAddr,
   output logic [dataW-1:0] InsCount,
   output logic             InsFault
);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, FAULT} fetchState_t;

   localparam logic [dataW-1:0] wordStep  = dataW'(4);
   localparam logic [dataW-1:0] countStep = dataW'(1);
   localparam logic [dataW-1:0] alignMask = ~dataW'(3);

   fetchState_t      state, stateNext;
   logic [dataW-1:0] pc, pcNext;
   logic [dataW-1:0] drainAddr, drainAddrNext;
   logic [dataW-1:0] rawIns, rawInsNext;
   logic [dataW-1:0] progAddr, progAddrNext;
   logic [dataW-1:0] insCount, insCountNext;
   logic             faultPend, faultPendNext;
   logic [dataW-1:0] redirectTarget;
   logic             trapRedirect;

   // The PC only ever holds word addresses.
   assign redirectTarget = RedirectAddr & alignMask;

`ifdef MISALIGN_TRAP_EN
   assign trapRedirect = Redirect && (RedirectAddr[1:0] != 2'b00);
   assign InsFault     = (state == FAULT);
`else
   assign trapRedirect = 1'b0;
   assign InsFault     = 1'b0;
`endif

   // While draining a wrong-path request, the memory keeps seeing the old address.
   assign IMemAddr = (state == DRAIN) ? drainAddr : pc;
   assign RawIns   = rawIns;
   assign ProgAddr = progAddr;
   assign LinkAddr = progAddr + wordStep;
   assign InsCount = insCount;

   // Next-state logic, datapath next values and handshake outputs.
   always_comb begin
      // NOTE: everything written below gets a default first, so no path through the case can infer a latch.
      stateNext     = state;
      pcNext        = pc;
      drainAddrNext = drainAddr;
      rawInsNext    = rawIns;
      progAddrNext  = progAddr;
      insCountNext  = insCount;
      faultPendNext = faultPend;
      IMemReq       = 1'b0;
      InsValid      = 1'b0;

      case (state)
         IDLE: begin
            stateNext = FETCH;
            if (trapRedirect) begin
               progAddrNext = RedirectAddr;
               stateNext    = FAULT;
            end
         end

         FETCH: begin
            IMemReq = 1'b1;
            if (Redirect) begin
               pcNext = redirectTarget;
               if (!IMemAck) begin
                  drainAddrNext = pc;
                  stateNext     = DRAIN;
               end
               if (trapRedirect) begin
                  progAddrNext  = RedirectAddr;
                  faultPendNext = 1'b1;
                  if (IMemAck) begin
                     stateNext = FAULT;
                  end
               end
            end else if (IMemAck) begin
               rawInsNext   = IMemData;
               progAddrNext = pc;
               pcNext       = pc + wordStep;
               stateNext    = HOLD;
            end
         end

         DRAIN: begin
            IMemReq = 1'b1;
            if (Redirect) begin
               pcNext = redirectTarget;
               if (trapRedirect) begin
                  progAddrNext  = RedirectAddr;
                  faultPendNext = 1'b1;
               end
            end
            if (IMemAck) begin
               stateNext = faultPendNext ? FAULT : FETCH;
            end
         end

         HOLD: begin
            InsValid = 1'b1;
            // A redirect kills the held instruction even if the decoder is ready.
            if (Redirect) begin
               pcNext    = redirectTarget;
               stateNext = FETCH;
               if (trapRedirect) begin
                  progAddrNext = RedirectAddr;
                  stateNext    = FAULT;
               end
            end else if (InsReady) begin
               insCountNext = insCount + countStep;
               stateNext    = FETCH;
            end
         end

         FAULT: stateNext = FAULT;

         default: stateNext = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (Reset) begin
         state     <= IDLE;
         pc        <= ResetVector;
         drainAddr <= ResetVector;
         rawIns    <= '0;
         progAddr  <= ResetVector;
         insCount  <= '0;
         faultPend <= 1'b0;
      end else begin
         state     <= stateNext;
         pc        <= pcNext;
         drainAddr <= drainAddrNext;
         rawIns    <= rawInsNext;
         progAddr  <= progAddrNext;
         insCount  <= insCountNext;
         faultPend <= faultPendNext;
      end
   end

endmodule

// File: tb/tb_fetch_unit_r32i.sv
// tb_fetch_unit_r32i: randomized self-checking bench for fetch_unit_r32i.
// A bench-side memory answers fetches with configurable wait states. A
// transaction-level reference tracks the architectural PC, the instruction
// the decoder should currently see, and how many instructions were handed over.
// Define MISALIGN_TRAP_EN to also exercise the misaligned-redirect trap.

module tb_fetch_unit_r32i;

   localparam logic [31:0] resetVec = 32'h0000_0100;

   logic        Clock;
   logic        Reset;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemData;
   logic        InsValid;
   logic        InsReady;
   logic [31:0] RawIns;
   logic [31:0] ProgAddr;
   logic [31:0] LinkAddr;
   logic        Redirect;
   logic [31:0] RedirectAddr;
   logic [31:0] InsCount;
   logic        InsFault;

   fetch_unit_r32i #(
      .dataW       (32),
      .ResetVector (resetVec)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .IMemReq      (IMemReq),
      .IMemAddr     (IMemAddr),
      .IMemAck      (IMemAck),
      .IMemData     (IMemData),
      .InsValid     (InsValid),
      .InsReady     (InsReady),
      .RawIns       (RawIns),
      .ProgAddr     (ProgAddr),
      .LinkAddr     (LinkAddr),
      .Redirect     (Redirect),
      .RedirectAddr (RedirectAddr),
      .InsCount     (InsCount),
      .InsFault     (InsFault)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference state: what the decoder should see and where fetching should be.
   logic [31:0] expPc;
   bit          held;
   logic [31:0] heldAddr;
   logic [31:0] heldData;
   logic [31:0] modelCount;
   bit          reqWrong;
   int          totalDelivered = 0;

   // Bench memory and protocol bookkeeping.
   int          waitCfg;
   bit          randWaits;
   int          reqAge;
   bit          prevPending;
   logic [31:0] prevAddr;
   int          sinceReset;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] pickTarget();
      case ($urandom_range(0, 3))
         0: return 32'hFFFF_FFFC;
         1: return 32'hFFFF_FFF8;
`ifndef MISALIGN_TRAP_EN
         2: return $urandom();
`endif
         default: return $urandom() & 32'hFFFF_FFFC;
      endcase
   endfunction

   // Holds reset across a rising edge, checks the reset outputs, releases
   // reset at a falling edge and clears the reference.
   task automatic doReset();
      Reset        = 1'b1;
      IMemAck      = 1'b0;
      IMemData     = '0;
      InsReady     = 1'b0;
      Redirect     = 1'b0;
      RedirectAddr = '0;
      repeat (2) @(negedge Clock);
      check("rstReq",      IMemReq,  1'b0);
      check("rstValid",    InsValid, 1'b0);
      check("rstRawIns",   RawIns,   32'h0);
      check("rstProgAddr", ProgAddr, resetVec);
      check("rstLinkAddr", LinkAddr, resetVec + 32'd4);
      check("rstCount",    InsCount, 32'h0);
      check("rstFault",    InsFault, 1'b0);
      expPc       = resetVec;
      held        = 1'b0;
      modelCount  = '0;
      reqWrong    = 1'b0;
      reqAge      = 0;
      prevPending = 1'b0;
      sinceReset  = 0;
      Reset       = 1'b0;
   endtask

   // One clock cycle, entered and left at a falling edge: check outputs
   // against the reference, drive this cycle's inputs, then advance the reference.
   task automatic cycle(input bit rd, input logic [31:0] ra, input bit rdy);
      bit ack;
      bit nextHeld;

      if (sinceReset == 0) begin
         check("idleReq",  IMemReq,  1'b0);
         check("idleAddr", IMemAddr, resetVec);
      end else begin
         check("reqXorValid", IMemReq, !InsValid);
      end
      check("insValid", InsValid, held);
      if (held) begin
         check("rawIns",   RawIns,   heldData);
         check("progAddr", ProgAddr, heldAddr);
         check("linkAddr", LinkAddr, heldAddr + 32'd4);
      end
      check("insCount", InsCount, modelCount);
      check("insFault", InsFault, 1'b0);
      if (prevPending) begin
         check("reqKept",  IMemReq,  1'b1);
         check("addrKept", IMemAddr, prevAddr);
      end
      if (IMemReq && !reqWrong) begin
         check("fetchAddr", IMemAddr, expPc);
      end

      ack          = IMemReq && (reqAge >= waitCfg);
      IMemAck      = ack;
      IMemData     = ack ? memWord(IMemAddr) : $urandom();
      Redirect     = rd;
      RedirectAddr = ra;
      InsReady     = rdy;

      prevPending = IMemReq && !ack;
      prevAddr    = IMemAddr;
      reqAge      = (IMemReq && !ack) ? reqAge + 1 : 0;
      if (ack && randWaits) waitCfg = $urandom_range(0, 3);

      nextHeld = held;
      if (held && rd) begin
         nextHeld = 1'b0;
      end else if (held && rdy) begin
         nextHeld = 1'b0;
         modelCount++;
         totalDelivered++;
      end
      if (ack && !reqWrong && !rd) begin
         nextHeld = 1'b1;
         heldAddr = IMemAddr;
         heldData = memWord(IMemAddr);
         expPc    = IMemAddr + 32'd4;
      end
      if (ack) reqWrong = 1'b0;
      if (rd) begin
         expPc = ra & 32'hFFFF_FFFC;
         if (IMemReq && !ack) reqWrong = 1'b1;
      end
      held = nextHeld;
      sinceReset++;
      @(negedge Clock);
   endtask

   initial begin
      Reset     = 1'b1;
      waitCfg   = 0;
      randWaits = 1'b0;
      doReset();

      // Zero-wait fetches from the reset vector, then the decoder stalls five cycles.
      cycle(1'b0, '0, 1'b1);
      check("firstReq",  IMemReq,  1'b1);
      check("firstAddr", IMemAddr, 32'h0000_0100);
      cycle(1'b0, '0, 1'b1);
      check("firstIns",  RawIns,   32'h0050_0093);
      check("firstPa",   ProgAddr, 32'h0000_0100);
      check("firstLink", LinkAddr, 32'h0000_0104);
      repeat (2) cycle(1'b0, '0, 1'b1);
      repeat (5) cycle(1'b0, '0, 1'b0);
      waitCfg = 3;
      cycle(1'b0, '0, 1'b1);

      // Redirect while the fetch at 0x108 waits; the stale ack is drained.
      cycle(1'b0, '0, 1'b1);
      cycle(1'b1, 32'h0000_0200, 1'b1);
      repeat (6) cycle(1'b0, '0, 1'b0);

      // Redirect in HOLD with the decoder ready: nothing is counted.
      cycle(1'b1, 32'h0000_0300, 1'b1);
      check("redirCount", InsCount, 32'd2);
      check("redirValid", InsValid, 1'b0);
      check("redirAddr",  IMemAddr, 32'h0000_0300);
      waitCfg = 0;
      repeat (3) cycle(1'b0, '0, 1'b1);

      // Fetch from the top word of the address space; PC and LinkAddr wrap.
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
      cycle(1'b0, '0, 1'b1);
      check("wrapPa",   ProgAddr, 32'hFFFF_FFFC);
      check("wrapLink", LinkAddr, 32'h0000_0000);
      cycle(1'b0, '0, 1'b1);
      check("wrapNext", IMemAddr, 32'h0000_0000);
      repeat (2) cycle(1'b0, '0, 1'b1);

      // Random wait states, stalls and redirects, with a reset in the middle.
      randWaits = 1'b1;
      for (int i = 0; i < 600; i++) begin
         bit rd;
         if (i == 300) doReset();
         rd = (sinceReset > 0) && ($urandom_range(0, 6) == 0);
         cycle(rd, rd ? pickTarget() : 32'h0, $urandom_range(0, 3) != 0);
      end
      check("enoughTraffic", totalDelivered >= 40, 1'b1);

`ifdef MISALIGN_TRAP_EN
      // Misaligned redirect while a fetch is outstanding: drain, then trap.
      randWaits = 1'b0;
      waitCfg   = 5;
      doReset();
      cycle(1'b0, '0, 1'b1);
      IMemAck      = 1'b0;
      Redirect     = 1'b1;
      RedirectAddr = 32'h0000_0202;
      @(negedge Clock);
      Redirect = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (InsFault) break;
         IMemAck  = IMemReq;
         IMemData = $urandom();
         @(negedge Clock);
      end
      IMemAck = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("trapFault", InsFault, 1'b1);
         check("trapReq",   IMemReq,  1'b0);
         check("trapValid", InsValid, 1'b0);
         check("trapPa",    ProgAddr, 32'h0000_0202);
         Redirect     = 1'b1;
         RedirectAddr = 32'h0000_0400;
         InsReady     = 1'b1;
         @(negedge Clock);
      end
      doReset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
